act_unit: RTL and testbench

Parametrised, multi-channel activation stage that succeeds the single-lane leaky ReLU. Applies one of four run-time selectable activations (bypass, ReLU, leaky ReLU with programmable shift, clipped ReLU) to CHANNELS signed fixed-point lanes in parallel. It has a two-stage valid/ready pipeline with full backpressure, and sits between the convolution accumulator/requantiser and the next layer's input buffer.

---
 rtl/act_pkg.sv | 15 +
 rtl/act_lane.sv | 40 ++++
 rtl/act_unit.sv | 128 ++++++++++++
 tb/tb_act_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared definitions for the multi-channel activation stage: activation
// mode encoding and the default lane format.
package act_pkg;

    localparam int ACT_DATA_WIDTH = 16;
    localparam int ACT_FRAC_WIDTH = 8;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLIP   = 2'd3
    } act_mode_e;

endpackage

// File: rtl/act_lane.sv
// Single-lane activation function (combinational). Also flags lanes that
// the clipped ReLU bounded from above so the caller can count them.
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = ACT_DATA_WIDTH
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  act_mode_e                    mode,
    input  logic        [3:0]            alpha_shift,
    input  logic signed [DATA_WIDTH-1:0] clip_max,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         clipped
);

    logic neg;

    assign neg = x[DATA_WIDTH-1];

    // Every result is no larger in magnitude than x, so no saturation is needed.
    always_comb begin
        y       = x;
        clipped = 1'b0;
        case (mode)
            ACT_BYPASS: y = x;
            ACT_RELU:   y = neg ? '0 : x;
            ACT_LEAKY:  y = neg ? (x >>> alpha_shift) : x;
            ACT_CLIP: begin
                clipped = (x > clip_max);
                if (neg) begin
                    y = '0;
                end else if (clipped) begin
                    y = clip_max;
                end
            end
            default: y = x;
        endcase
    end

endmodule

// File: rtl/act_unit.sv
// Multi-channel activation stage: two-stage valid/ready pipeline applying a
// per-beat selectable activation to CHANNELS lanes, plus a clip event counter.
module act_unit
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = ACT_DATA_WIDTH,
    parameter int FRAC_WIDTH = ACT_FRAC_WIDTH,
    parameter int CHANNELS   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     mode,
    input  logic [3:0]                     alpha_shift,
    input  logic [DATA_WIDTH-1:0]          clip_max,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]           clip_count,
    input  logic                           cnt_clear
);

    localparam int POP_W = $clog2(CHANNELS + 1);
    localparam int SUM_W = CNT_WIDTH + 1;

    if (FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
        $error("act_unit: FRAC_WIDTH must be smaller than DATA_WIDTH");
    end

    logic                           s2_ready;
    logic                           s1_adv;
    logic                           accept;
    logic                           vld_p1;
    logic                           vld_p2;
    logic [CHANNELS*DATA_WIDTH-1:0] data_p1;
    logic [CHANNELS*DATA_WIDTH-1:0] res_p1;
    logic [CHANNELS*DATA_WIDTH-1:0] data_p2;
    act_mode_e                      mode_p1;
    logic [3:0]                     shift_p1;
    logic signed [DATA_WIDTH-1:0]   clip_max_p1;
    logic [CHANNELS-1:0]            clip_vec_p1;
    logic [CNT_WIDTH-1:0]           clip_cnt;

    function automatic logic [POP_W-1:0] popcount(input logic [CHANNELS-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [POP_W-1:0]     b);
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + SUM_W'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // in_ready is forced high during reset, but nothing is accepted then.
    assign s2_ready = !vld_p2 || out_ready;
    assign s1_adv   = vld_p1 && s2_ready;
    assign in_ready = rst || !vld_p1 || s2_ready;
    assign accept   = in_valid && in_ready && !rst;

    // ---- stage 1: capture beat together with its configuration ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_p1     <= in_data;
            mode_p1     <= act_mode_e'(mode);
            shift_p1    <= alpha_shift;
            clip_max_p1 <= clip_max;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        act_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .x           (data_p1[k*DATA_WIDTH +: DATA_WIDTH]),
            .mode        (mode_p1),
            .alpha_shift (shift_p1),
            .clip_max    (clip_max_p1),
            .y           (res_p1[k*DATA_WIDTH +: DATA_WIDTH]),
            .clipped     (clip_vec_p1[k])
        );
    end

    // ---- stage 2: registered result drives the output port ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
        end else begin
            if (s2_ready) begin
                vld_p2 <= vld_p1;
            end
            if (s1_adv) begin
                data_p2 <= res_p1;
            end
        end
    end

    // Clip events are counted as the beat moves into stage 2; clear wins.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            clip_cnt <= '0;
        end else if (s1_adv && mode_p1 == ACT_CLIP) begin
            clip_cnt <= sat_add(clip_cnt, popcount(clip_vec_p1));
        end
    end

    assign out_valid  = vld_p2;
    assign out_data   = data_p2;
    assign clip_count = clip_cnt;

endmodule

// File: tb/tb_act_unit.sv
// Scoreboard bench for act_unit: directed vectors plus randomized beats
// checked against an arithmetic reference model.
module tb_act_unit;

    typedef struct packed {
        logic [63:0] d;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [3:0]  alpha_shift;
    logic [15:0] clip_max;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [15:0] clip_count;
    logic        cnt_clear;

    int   n_chk = 0;
    int   n_fail = 0;
    int   model_cnt = 0;
    int   bp_mode = 0;
    exp_t q[$];

    logic [15:0] lk_in [6] = '{16'h0100, 16'hFF00, 16'hFE00, 16'hFF80, 16'hFC00, 16'h0001};
    logic [15:0] lk_out[6] = '{16'h0100, 16'hFFFE, 16'hFFFC, 16'hFFFF, 16'hFFF8, 16'h0001};

    act_unit #(
        .DATA_WIDTH (16),
        .FRAC_WIDTH (8),
        .CHANNELS   (4),
        .CNT_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .alpha_shift (alpha_shift),
        .clip_max    (clip_max),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .clip_count  (clip_count),
        .cnt_clear   (cnt_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, floor division for the leaky slope.
    function automatic logic [15:0] ref_lane(input int m, input int s, input int cm, input int x);
        int d;
        int r;
        r = x;
        if (m == 1) begin
            r = (x < 0) ? 0 : x;
        end else if (m == 2) begin
            if (x < 0) begin
                d = 1 << s;
                r = x / d;
                if (r * d != x) r = r - 1;
            end
        end else if (m == 3) begin
            r = (x < 0) ? 0 : ((x > cm) ? cm : x);
        end
        return 16'(r);
    endfunction

    function automatic logic [63:0] model_beat(input int m, input int s, input logic [15:0] cm,
                                               input logic [63:0] d);
        logic [63:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*16 +: 16] = ref_lane(m, s, int'($signed(cm)), int'($signed(d[k*16 +: 16])));
        end
        return r;
    endfunction

    function automatic int model_clips(input int m, input logic [15:0] cm, input logic [63:0] d);
        int n;
        n = 0;
        if (m == 3) begin
            for (int k = 0; k < 4; k++) begin
                if (int'($signed(d[k*16 +: 16])) > int'($signed(cm))) n++;
            end
        end
        return n;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [1:0] m, input logic [3:0] s, input logic [15:0] cm,
                             input logic [63:0] d, input bit use_exp, input logic [63:0] exp_d);
        bit   acc;
        int   waits;
        exp_t e;
        mode        = m;
        alpha_shift = s;
        clip_max    = cm;
        in_data     = d;
        in_valid    = 1'b1;
        acc   = 1'b0;
        waits = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 200) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL accept_timeout: in_ready stuck 0, required 1");
                    break;
                end
            end
        end
        if (acc) begin
            model_cnt = model_cnt + model_clips(m, cm, d);
            if (model_cnt > 65535) model_cnt = 65535;
            e.d   = use_exp ? exp_d : model_beat(m, s, cm, d);
            e.cnt = model_cnt;
            q.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q.size() != 0 || out_valid) && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_done", (w < 500), 1'b1);
    endtask

    // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks stall stability.
    bit          stalled_prev = 1'b0;
    logic [63:0] held_data;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("stall_valid_hold", out_valid, 1'b1);
                check("stall_data_hold", out_data, held_data);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h, required no output", out_data);
                end else begin
                    e = q.pop_front();
                    check("out_data", out_data, e.d);
                    check("clip_count", {48'h0, clip_count}, {32'h0, e.cnt});
                end
            end
            stalled_prev = out_valid && !out_ready;
            held_data    = out_data;
        end
    end

    initial begin
        logic [63:0] d;
        rst         = 1'b1;
        in_valid    = 1'b0;
        mode        = 2'd0;
        alpha_shift = 4'd0;
        clip_max    = 16'h0;
        in_data     = 64'h0;
        cnt_clear   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready_during_rst", in_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check("rst_clip_count", clip_count, 16'h0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Leaky shift-7 vectors, one at a time, with latency check.
        for (int i = 0; i < 6; i++) begin
            send_beat(2'd2, 4'd7, 16'h0, {48'h0, lk_in[i]}, 1'b1, {48'h0, lk_out[i]});
            @(negedge clk);
            check("latency_c1_invalid", out_valid, 1'b0);
            @(negedge clk);
            check("latency_c2_valid", out_valid, 1'b1);
            @(posedge clk);
            #1;
        end

        send_beat(2'd3, 4'd0, 16'h0600, {16'h0300, 16'hFF00, 16'h0600, 16'h0800}, 1'b1,
                  {16'h0300, 16'h0000, 16'h0600, 16'h0600});
        drain();
        check("clip_count_one", clip_count, 16'd1);

        send_beat(2'd1, 4'd0, 16'h0, {16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000}, 1'b1,
                  {16'h0000, 16'h0000, 16'h7FFF, 16'h0000});
        send_beat(2'd0, 4'd0, 16'h0, {16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000}, 1'b1,
                  {16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000});
        drain();

        // Backpressure: two beats fill the pipeline, then 6 more behind a stall.
        bp_mode = 2;
        idle(2);
        send_beat(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'h1000, {$urandom, $urandom}, 1'b0, 64'h0);
        send_beat(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'h1000, {$urandom, $urandom}, 1'b0, 64'h0);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_beat(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'h1000,
                              {$urandom, $urandom}, 1'b0, 64'h0);
                end
            end
            begin
                idle(4);
                bp_mode = 0;
            end
        join
        drain();

        // Mode switch on the very next beat must not affect the earlier one.
        d = {16'hFF00, 16'h8000, 16'h0010, 16'hFFF0};
        send_beat(2'd2, 4'd3, 16'h0, d, 1'b1, {16'hFFE0, 16'hF000, 16'h0010, 16'hFFFE});
        send_beat(2'd1, 4'd3, 16'h0, d, 1'b1, {16'h0000, 16'h0000, 16'h0010, 16'h0000});
        drain();

        // Random traffic with random downstream stalls and input gaps.
        bp_mode = 1;
        for (int i = 0; i < 400; i++) begin
            send_beat(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      16'($urandom_range(0, 32767)), {$urandom, $urandom}, 1'b0, 64'h0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        bp_mode = 0;

        cnt_clear = 1'b1;
        idle(1);
        cnt_clear = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        check("cnt_clear", clip_count, 16'h0);
        @(posedge clk);
        #1;

        // Clear coincides with a 2-lane clip event: clear wins.
        send_beat(2'd3, 4'd0, 16'h0100, {16'hFF00, 16'h0050, 16'h0300, 16'h0200}, 1'b1,
                  {16'h0000, 16'h0050, 16'h0100, 16'h0100});
        cnt_clear = 1'b1;
        q[q.size()-1].cnt = 32'd0;
        model_cnt = 0;
        idle(1);
        cnt_clear = 1'b0;
        drain();

        // Saturation of the clip counter: every lane clips in every beat.
        for (int i = 0; i < 16400; i++) begin
            d = {16'($urandom_range(1, 32767)), 16'($urandom_range(1, 32767)),
                 16'($urandom_range(1, 32767)), 16'($urandom_range(1, 32767))};
            send_beat(2'd3, 4'd0, 16'h0000, d, 1'b0, 64'h0);
        end
        drain();
        check("clip_count_saturated", clip_count, 16'hFFFF);

        // Reset with both stages full.
        bp_mode = 2;
        idle(2);
        send_beat(2'd3, 4'd0, 16'h0010, {4{16'h0100}}, 1'b0, 64'h0);
        send_beat(2'd3, 4'd0, 16'h0010, {4{16'h0200}}, 1'b0, 64'h0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = {4{16'h1234}};
        mode     = 2'd0;
        q.delete();
        model_cnt = 0;
        @(negedge clk);
        check("in_ready_rst_full", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        bp_mode  = 0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 64'h0);
        check("midrst_clip_count", clip_count, 16'h0);
        check("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        check("no_accept_in_rst", out_valid, 1'b0);
        @(posedge clk);
        #1;
        send_beat(2'd1, 4'd0, 16'h0, {16'h0005, 16'hFFFB, 16'h7000, 16'h9000}, 1'b1,
                  {16'h0005, 16'h0000, 16'h7000, 16'h0000});
        @(negedge clk);
        check("post_rst_lat_c1", out_valid, 1'b0);
        @(negedge clk);
        check("post_rst_lat_c2", out_valid, 1'b1);
        drain();
        check("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
